console_streamer: RTL

Drop-in replacement for the bring-up CPU stub. It has the same memory-port signature and the same console-output convention: writes to the all-ones address are printed. Instead of emitting a hardwired sequence, it fetches a byte string from memory, word by word, and streams each byte to the console. It stops on a NUL terminator or a byte limit, then asserts `done`. It is used as the default top-level core in simulation until the out-of-order core boots.

---
 rtl/console_pkg.sv | 19 +
 rtl/console_streamer.sv | 135 +++++++++++++
 2 files changed

// File: rtl/console_pkg.sv
// Shared types and constants for the console streaming core.
package console_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    EMIT,
    DONE
  } console_state_t;

  localparam logic [63:0] CONSOLE_MMIO_ADDR = 64'hffff_ffff_ffff_ffff;

  // A byte ends the stream only when NUL termination is enabled.
  function automatic logic is_terminator(input logic [7:0] b, input logic stop_on_nul);
    return stop_on_nul && (b == 8'h00);
  endfunction

endpackage

// File: rtl/console_streamer.sv
// Fetches a byte string from memory one 64-bit word at a time and writes each
// byte to the console MMIO address until a NUL or the byte limit is reached.
module console_streamer
  import console_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR    = 64'h0,
  parameter logic [63:0] CONSOLE_ADDR = CONSOLE_MMIO_ADDR,
  parameter int unsigned MAX_BYTES    = 4096,
  parameter bit          STOP_ON_NUL  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        done,
  output logic        mem_ren,
  output logic [63:0] mem_raddr,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  output logic        mem_wen,
  output logic [63:0] mem_waddr,
  output logic [63:0] mem_wdata
);

  // A zero byte limit would give a zero-width counter; keep one bit minimum.
  localparam int CW = (MAX_BYTES > 0) ? $clog2(MAX_BYTES + 1) : 1;

  console_state_t state_q;
  logic [63:0]    addr_q;
  logic [63:0]    shreg_q;
  logic [2:0]     idx_q;
  logic [CW-1:0]  cnt_q;

  logic [CW-1:0]  cnt_inc;
  logic           hit_limit;
  logic           cur_term;
  logic           first_term;
  logic           next_term;

  assign mem_waddr = CONSOLE_ADDR;

  always_comb begin
    cnt_inc    = cnt_q + CW'(1);
    hit_limit  = (cnt_inc == CW'(MAX_BYTES));
    cur_term   = is_terminator(shreg_q[7:0], STOP_ON_NUL);
    first_term = is_terminator(mem_rdata[7:0], STOP_ON_NUL);
    next_term  = is_terminator(shreg_q[15:8], STOP_ON_NUL);
  end

  // Outputs are registered one state ahead so each reflects the state the FSM
  // is entering; nothing from the memory inputs reaches a port combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= BASE_ADDR;
      shreg_q   <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      done      <= 1'b0;
      mem_ren   <= 1'b0;
      mem_raddr <= '0;
      mem_wen   <= 1'b0;
      mem_wdata <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      case (state_q)
        IDLE: begin
          if (MAX_BYTES == 0) begin
            state_q <= DONE;
            done    <= 1'b1;
          end else begin
            state_q   <= READ;
            mem_ren   <= 1'b1;
            mem_raddr <= addr_q;
          end
        end

        READ: begin
          state_q   <= WAIT;
          mem_ren   <= 1'b0;
          mem_raddr <= '0;
        end

        WAIT: begin
          if (mem_rvalid) begin
            state_q   <= EMIT;
            shreg_q   <= mem_rdata;
            idx_q     <= '0;
            mem_wen   <= !first_term;
            mem_wdata <= first_term ? 64'h0 : {56'b0, mem_rdata[7:0]};
          end
        end

        EMIT: begin
          if (cur_term) begin
            state_q   <= DONE;
            done      <= 1'b1;
            mem_wen   <= 1'b0;
            mem_wdata <= '0;
          end else begin
            cnt_q   <= cnt_inc;
            shreg_q <= shreg_q >> 8;
            idx_q   <= idx_q + 3'd1;
            if (hit_limit) begin
              state_q   <= DONE;
              done      <= 1'b1;
              mem_wen   <= 1'b0;
              mem_wdata <= '0;
            end else if (idx_q == 3'd7) begin
              state_q   <= READ;
              addr_q    <= addr_q + 64'd8;
              mem_ren   <= 1'b1;
              mem_raddr <= addr_q + 64'd8;
              mem_wen   <= 1'b0;
              mem_wdata <= '0;
            end else begin
              mem_wen   <= !next_term;
              mem_wdata <= next_term ? 64'h0 : {56'b0, shreg_q[15:8]};
            end
          end
        end

        DONE: begin
          done    <= 1'b1;
          mem_ren <= 1'b0;
          mem_wen <= 1'b0;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
